// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store initiator for a word-addressed memory.
// Sub-word stores are performed as read-modify-write so memory only sees full-word writes.
`default_nettype none

module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LD     = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_WR     = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [2:0]  state_q,  state_d;
    logic        we_q,     we_d;
    logic [1:0]  size_q,   size_d;
    logic        uns_q,    uns_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic        err_q,    err_d;
    logic [31:0] merge_q,  merge_d;
    logic [31:0] rdata_q,  rdata_d;

    logic        accept;
    logic        req_bad;
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] lane_bytes;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] merge_mask;
    logic [31:0] merge_ins;
    logic [31:0] merged;
    logic        mem_active;

    assign accept = req_valid && (state_q == ST_IDLE);

    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = req_addr[0];
            SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Little-endian lane selection driven by the latched byte offset.
    assign byte_shift = {addr_q[1:0], 3'b000};
    assign half_shift = {addr_q[1], 4'b0000};
    assign lane_bytes = mem_rdata >> byte_shift;
    assign sel_half   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        case (size_q)
            SZ_BYTE: load_data = uns_q ? {24'd0, lane_bytes[7:0]}
                                       : {{24{lane_bytes[7]}}, lane_bytes[7:0]};
            SZ_HALF: load_data = uns_q ? {16'd0, sel_half}
                                       : {{16{sel_half[15]}}, sel_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        if (size_q == SZ_HALF) begin
            merge_mask = 32'h0000_FFFF << half_shift;
            merge_ins  = {16'd0, wdata_q[15:0]} << half_shift;
        end else begin
            merge_mask = 32'h0000_00FF << byte_shift;
            merge_ins  = {24'd0, wdata_q[7:0]} << byte_shift;
        end
    end

    assign merged = (mem_rdata & ~merge_mask) | merge_ins;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    if (req_bad) begin
                        rdata_d = 32'd0;
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_LD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LD: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                merge_d = merged;
                state_d = ST_WR;
            end
            ST_WR: begin
                rdata_d = 32'd0;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            merge_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode from state so an async reset clears them immediately.
    assign mem_active = (state_q == ST_LD) || (state_q == ST_RMW_RD) || (state_q == ST_WR);
    assign req_ready  = (state_q == ST_IDLE);
    assign mem_read   = (state_q == ST_LD) || (state_q == ST_RMW_RD);
    assign mem_write  = (state_q == ST_WR);
    assign mem_addr   = mem_active ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = (state_q == ST_WR) ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : 32'd0;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign resp_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a small word memory.
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];

    int n_total = 0;
    int n_bad   = 0;
    int n_acc   = 0;
    int n_resp  = 0;

    int          r_k, r_nrd, r_nwr;
    logic        r_err, r_busy_ready, r_both, r_pulse_after;
    logic [31:0] r_rdata, r_rd_addr, r_wr_addr, r_wr_data;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        if (rst_n && req_valid && req_ready) n_acc++;
        if (resp_valid) n_resp++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and observe it through the end of RESP.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic hold);
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        r_k = 0; r_nrd = 0; r_nwr = 0; r_busy_ready = 1'b0; r_both = 1'b0;
        r_rd_addr = 32'd0; r_wr_addr = 32'd0; r_wr_data = 32'd0;
        while (!resp_valid && r_k < 8) begin
            r_busy_ready = r_busy_ready | req_ready;
            r_both       = r_both | (mem_read & mem_write);
            if (mem_read)  begin r_nrd++; r_rd_addr = mem_addr; end
            if (mem_write) begin r_nwr++; r_wr_addr = mem_addr; r_wr_data = mem_wdata; end
            @(posedge clk); #1;
            r_k++;
        end
        chk("resp_seen", {31'd0, resp_valid}, 32'd1);
        r_busy_ready = r_busy_ready | req_ready;
        r_err   = resp_err;
        r_rdata = resp_rdata;
        @(posedge clk); #1;
        r_pulse_after = resp_valid;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[8'h20 >> 2] = 32'h1122_3344;
        mem[8'h30 >> 2] = 32'h80FF_7F01;
        mem[8'h40 >> 2] = 32'h5566_7788;
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_outs", {26'd0, resp_valid, resp_err, mem_read, mem_write, 2'b00}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Word store then word load
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        chk("wst_lat", r_k, 1);
        chk("wst_nwr", r_nwr, 1);
        chk("wst_nrd", r_nrd, 0);
        chk("wst_addr", r_wr_addr, 32'h10);
        chk("wst_data", r_wr_data, 32'hDEAD_BEEF);
        chk("wst_busy", {31'd0, r_busy_ready}, 32'd0);
        chk("wst_pulse", {31'd0, r_pulse_after}, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("wld_lat", r_k, 1);
        chk("wld_rdata", r_rdata, 32'hDEAD_BEEF);
        chk("wld_err", {31'd0, r_err}, 32'd0);
        chk("wld_raddr", r_rd_addr, 32'h10);

        // Byte read-modify-write
        issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AB, 1'b0);
        chk("rmw_lat", r_k, 2);
        chk("rmw_nrd", r_nrd, 1);
        chk("rmw_nwr", r_nwr, 1);
        chk("rmw_both", {31'd0, r_both}, 32'd0);
        chk("rmw_wdata", r_wr_data, 32'h11AB_3344);
        chk("rmw_mem", mem[8'h20 >> 2], 32'h11AB_3344);
        chk("rmw_rdata", r_rdata, 32'd0);

        // Halfword RMW into upper half
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_5AA5, 1'b0);
        chk("hrmw_mem", mem[8'h20 >> 2], 32'h5AA5_3344);

        // Sign/zero extension
        issue(1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 1'b0);
        chk("lb_s", r_rdata, 32'hFFFF_FFFF);
        issue(1'b0, 2'b00, 1'b1, 32'h32, 32'h0, 1'b0);
        chk("lb_u", r_rdata, 32'h0000_00FF);
        issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1'b0);
        chk("lh_s", r_rdata, 32'hFFFF_80FF);
        issue(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0);
        chk("lh_u", r_rdata, 32'h0000_7F01);
        issue(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 1'b0);
        chk("lb_s_pos", r_rdata, 32'h0000_007F);

        // Misaligned / illegal requests
        issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
        chk("mis_w_lat", r_k, 0);
        chk("mis_w_err", {31'd0, r_err}, 32'd1);
        chk("mis_w_rdata", r_rdata, 32'd0);
        chk("mis_w_mem", r_nrd + r_nwr, 0);
        issue(1'b1, 2'b01, 1'b0, 32'h05, 32'h1234, 1'b0);
        chk("mis_h_lat", r_k, 0);
        chk("mis_h_err", {31'd0, r_err}, 32'd1);
        chk("mis_h_mem", r_nrd + r_nwr, 0);
        issue(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 1'b0);
        chk("sz11_err", {31'd0, r_err}, 32'd1);
        chk("sz11_lat", r_k, 0);
        chk("sz11_mem", r_nrd + r_nwr, 0);

        // Address wrap
        issue(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D, 1'b0);
        chk("wrap_addr", r_wr_addr, 32'hFFFF_FFFC);
        chk("wrap_mem", mem[63], 32'h0BAD_F00D);

        // Held req_valid across two requests
        n_acc = 0;
        issue(1'b1, 2'b10, 1'b0, 32'h50, 32'hCAFE_F00D, 1'b1);
        chk("hs_a_busy", {31'd0, r_busy_ready}, 32'd0);
        chk("hs_a_pulse", {31'd0, r_pulse_after}, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0);
        chk("hs_b_rdata", r_rdata, 32'hCAFE_F00D);
        chk("hs_b_busy", {31'd0, r_busy_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("hs_accepts", n_acc, 2);

        // Reset during RMW_RD of a byte store
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h99; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rr_inrmw", {31'd0, mem_read}, 32'd1);
        n_resp = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rr_outs", {26'd0, resp_valid, resp_err, mem_read, mem_write, 2'b00}, 32'd0);
        chk("rr_maddr", mem_addr, 32'd0);
        chk("rr_rdata", resp_rdata, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rr_mem", mem[8'h40 >> 2], 32'h5566_7788);
        chk("rr_noresp", n_resp, 0);
        chk("rr_ready", {31'd0, req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access unit. It sits between the CPU datapath and the word-addressed data memory, which has a combinational read and a posedge write. The block accepts byte, halfword and word load/store requests through a valid/ready handshake and drives the memory's mem_read/mem_write/addr/write_data/read_data interface. Loads are sign- or zero-extended. Sub-word stores are done as read-modify-write so that the memory only ever sees full-word writes.

## Interface
- No parameters. Data width is fixed at 32 bits, address width at 32 bits.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; misaligned or illegal-size request
- resp_rdata  out  32  extended load data; 0 for stores and errors
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable; memory captures on the next posedge
- mem_addr  out  32  always word-aligned: {addr[31:2],2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational memory read data

## Operation
- Accept: latch we/size/unsigned/addr/wdata into internal registers. After accept, the block ignores the req_* inputs until it returns to IDLE.
- Alignment check on accept:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - size 11 is always an error.
  - On error, go straight to RESP with resp_err=1 and issue no memory access.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], with k = addr[1:0]. A halfword uses lanes {addr[1],1} and {addr[1],0}.
- State machine, one state per cycle:
  - IDLE: req_ready=1. Transitions on accept:
    - error → RESP
    - load → LD
    - word store → WR
    - sub-word store → RMW_RD
  - LD: mem_read=1. At the clock edge, extract and extend the selected lane(s) of mem_rdata into resp_rdata. → RESP
  - RMW_RD: mem_read=1. At the clock edge, merge the new byte/half into mem_rdata and store the result in a merge register. → WR
  - WR: mem_write=1, mem_wdata = merged word (sub-word store) or req_wdata (word store). → RESP
  - RESP: resp_valid=1. → IDLE
- mem_addr holds the latched aligned address in LD/RMW_RD/WR and is 0 in IDLE/RESP.
- mem_wdata is 0 outside WR. mem_read and mem_write are never high together.
- resp_rdata is registered. It changes only on entry to RESP and holds its value until the next RESP.

## Timing
- Reset values:
  - state = IDLE, req_ready = 1
  - resp_valid = 0, resp_err = 0, resp_rdata = 0
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0
- Take accept at edge N. resp_valid is high in the cycle after:
  - error: edge N
  - load: edge N+1
  - word store: edge N+1 (memory written at edge N+1)
  - sub-word store: edge N+2 (memory written at edge N+2)
- Next accept can happen no earlier than the edge that ends RESP. There is no back-to-back pipelining.
- req_valid held during non-IDLE states is ignored and not accepted twice.
- rst_n asserted mid-operation:
  - immediately return to IDLE and deassert all memory and resp outputs
  - the in-flight response is dropped
  - a pending WR does not reach the memory if rst_n is low at its edge
- Address wrap: addr 0xFFFFFFFC word access maps to mem_addr 0xFFFFFFFC. There is no carry out and no special case.

## Test plan
- Word store then load:
  - stimulus: store addr=0x10, wdata=0xDEADBEEF, then load word addr=0x10
  - required: one mem_write cycle with mem_addr=0x10; load resp_rdata=0xDEADBEEF with resp_err=0; load latency 2 edges after accept
- Byte RMW:
  - stimulus: memory[0x20]=0x11223344, store byte addr=0x22, wdata=0xAB
  - required: mem_read cycle, then mem_write with mem_wdata=0x11AB3344; resp 3 edges after accept
- Extension:
  - stimulus: memory[0x30]=0x80FF7F01; signed byte load at addr 0x32
  - required: 0xFFFFFFFF; unsigned byte at 0x32 → 0x000000FF; signed half at 0x32 → 0xFFFF80FF; unsigned half at 0x30 → 0x00007F01
- Misaligned:
  - stimulus: word load at addr=0x06; half store at addr=0x05; size=11
  - required: each returns resp_valid with resp_err=1, resp_rdata=0, one edge after accept; no mem_read or mem_write cycle
- Handshake:
  - stimulus: hold req_valid=1 continuously with two queued requests
  - required: req_ready=0 from accept through RESP; exactly one accept per transaction; resp_valid is a 1-cycle pulse
- Reset mid-RMW:
  - stimulus: drop rst_n during RMW_RD of a byte store to 0x40
  - required: memory[0x40] unchanged; no resp_valid; outputs at reset values; req_ready=1 after rst_n rises
